axi_if_axil2reg: RTL and testbench
==================================

Name: axi_if_axil2reg

Overview:
- AXI4-Lite slave that terminates the 18-bit address / 32-bit data AXI-lite port exposed by the shell.
- Converts each AXI-lite read or write into a single-outstanding register-bus request for the downstream register file.
- Provides address-range decode error and access timeout so the host never hangs.
- Sits directly downstream of the shell AXI-lite interface and upstream of every register bank.

Parameters:
- AXIL_ADD_W, 18, AXI-lite address width.
- AXIL_DATA_W, 32, AXI-lite data width; AXIL_DATA_BYTES = AXIL_DATA_W/8.
- ADD_RANGE, 2**18, number of decoded bytes; addresses >= ADD_RANGE get DECERR.
- TIMEOUT, 1024, cycles to wait for reg_ack before SLVERR; must be >= 2.

Ports:
- clk  in  1  clock
- s_rst  in  1  synchronous active-high reset
- s_axil_awaddr  in  AXIL_ADD_W  write address
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
- s_axil_wdata  in  AXIL_DATA_W  write data
- s_axil_wstrb  in  AXIL_DATA_BYTES  byte strobes
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake
- s_axil_bresp  out  2  write response
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake
- s_axil_araddr  in  AXIL_ADD_W  read address
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
- s_axil_rdata  out  AXIL_DATA_W  read data
- s_axil_rresp  out  2  read response
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake
- reg_req_vld  out  1  register request valid
- reg_req_wen  out  1  1 = write, 0 = read
- reg_req_add  out  AXIL_ADD_W  word-aligned address (bits [1:0] forced to 0)
- reg_req_wdata  out  AXIL_DATA_W  write data
- reg_req_wstrb  out  AXIL_DATA_BYTES  write strobes
- reg_ack  in  1  one-cycle completion pulse from register file
- reg_rdata  in  AXIL_DATA_W  read data, valid with reg_ack

Behaviour:
- Clocking/reset: single clock domain, clk; s_rst is synchronous and active-high.
- Reset values: all valid, ready and reg_req_* outputs are 0; bresp, rresp and rdata are 0. Holding flags and the timeout counter clear. FSM returns to IDLE.
- Reset mid-transaction: the transaction is dropped silently, with no response.
- Input holding registers: one each for AW, W and AR.
  - awready = !aw_held; wready = !w_held; arready = !ar_held. All three are registered and go to 1 the cycle after reset deasserts.
  - A handshake sets the held flag; the flag clears when the FSM consumes the entry.
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, REQ, WRESP, RRESP.
- IDLE arbitration:
  - A write is pending when aw_held and w_held are both set; a read is pending when ar_held is set.
  - If both are pending, pick the opposite of last_wr; reset value of last_wr is 0, so the first tie goes to the write.
  - The chosen entry's flags clear on the transition.
- Address decode in IDLE:
  - addr >= ADD_RANGE: no register request; go directly to WRESP/RRESP with resp = 2'b11 (DECERR) and rdata = 0.
  - In range: reg_req_* are registered and reg_req_vld rises the cycle after the IDLE decision; go to REQ.
- REQ:
  - reg_req_vld and all reg_req_* are held stable until exit.
  - reg_ack = 1: latch reg_rdata (reads only); resp = 2'b00; move to the response state. reg_req_vld drops in the same edge.
  - Timeout counter increments each REQ cycle. When it reaches TIMEOUT-1 without ack, exit with resp = 2'b10 (SLVERR) and rdata = 0.
  - If ack and timeout coincide, ack wins.
- WRESP / RRESP:
  - bvalid/rvalid asserted; resp/data held until bready/rready, then return to IDLE.
  - reg_ack seen outside REQ is ignored.
- Latency, fastest in-range write: AW+W handshake at cycle N; IDLE decision N+1; reg_req_vld N+2; zero-wait ack N+2; bvalid N+3.
- Throughput: one transaction in flight. The next AW/W/AR may be captured while a transaction is in progress (one-deep buffering per channel).
- Address bits [1:0] are ignored; wstrb is passed through unmodified, including all-zero.

Test Plan:
- Single write 0x00104 / data 0xA5A5_5A5A / strb 0xF, ack after 3 cycles -> reg_req_wen=1, reg_req_add=0x00104, one request; bresp=00 after ack.
- W presented 2 cycles before AW -> request issued only after AW; wdata intact; exactly one bvalid.
- Read 0x00010, ack with reg_rdata=0x1234_5678 -> rdata=0x1234_5678, rresp=00; rready held low 5 cycles -> rvalid and rdata stable throughout.
- Write and read pending in the same IDLE cycle after reset -> write issued first, read next; repeat with both pending -> read first (alternation).
- Read 0x3FFFC with ADD_RANGE=0x20000 -> no reg_req_vld, rresp=11, rdata=0. Read in range, no ack, TIMEOUT=16 -> rresp=10 after 16 REQ cycles; late ack ignored.
- Assert s_rst while in REQ -> next cycle reg_req_vld=0, no B/R response; a fresh write completes normally afterwards.

Source files
------------

// File: rtl/axi_if_axil2reg.sv
// axi_if_axil2reg
//   AXI4-Lite slave that turns each host read or write into a single
//   outstanding register-bus request. Out-of-range addresses get DECERR
//   without touching the register bus. A request that sees no reg_ack
//   within TIMEOUT cycles gets SLVERR, so the host never hangs.
//
// Ports
//   clk, s_rst           clock, synchronous active-high reset
//   s_axil_aw*/w*/b*     AXI-lite write address, data and response channels
//   s_axil_ar*/r*        AXI-lite read address and data channels
//   reg_req_*            register request (vld held until ack or timeout)
//   reg_ack, reg_rdata   one-cycle completion pulse and read data
//
// FSM states
//   state    | meaning
//   ST_IDLE  | arbitrate held AW+W / AR entries, decode the address
//   ST_REQ   | register request outstanding, timeout running
//   ST_WRESP | bvalid up, waiting for bready
//   ST_RRESP | rvalid up, waiting for rready

module axi_if_axil2reg #(
   parameter int unsigned AXIL_ADD_W      = 18,
   parameter int unsigned AXIL_DATA_W     = 32,
   parameter int unsigned AXIL_DATA_BYTES = AXIL_DATA_W / 8,
   parameter int unsigned ADD_RANGE       = 2**18,
   parameter int unsigned TIMEOUT         = 1024
) (
   input  logic                       clk,
   input  logic                       s_rst,
   input  logic [AXIL_ADD_W-1:0]      s_axil_awaddr,
   input  logic                       s_axil_awvalid,
   output logic                       s_axil_awready,
   input  logic [AXIL_DATA_W-1:0]     s_axil_wdata,
   input  logic [AXIL_DATA_BYTES-1:0] s_axil_wstrb,
   input  logic                       s_axil_wvalid,
   output logic                       s_axil_wready,
   output logic [1:0]                 s_axil_bresp,
   output logic                       s_axil_bvalid,
   input  logic                       s_axil_bready,
   input  logic [AXIL_ADD_W-1:0]      s_axil_araddr,
   input  logic                       s_axil_arvalid,
   output logic                       s_axil_arready,
   output logic [AXIL_DATA_W-1:0]     s_axil_rdata,
   output logic [1:0]                 s_axil_rresp,
   output logic                       s_axil_rvalid,
   input  logic                       s_axil_rready,
   output logic                       reg_req_vld,
   output logic                       reg_req_wen,
   output logic [AXIL_ADD_W-1:0]      reg_req_add,
   output logic [AXIL_DATA_W-1:0]     reg_req_wdata,
   output logic [AXIL_DATA_BYTES-1:0] reg_req_wstrb,
   input  logic                       reg_ack,
   input  logic [AXIL_DATA_W-1:0]     reg_rdata
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Timeout is a down-counter loaded with TIMEOUT-1 on entry to ST_REQ;
   // terminal count 0 marks the last REQ cycle.
   localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WRESP, ST_RRESP} state_t;

   state_t                     state_q, state_d;
   logic                       aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
   logic                       awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
   logic [AXIL_ADD_W-1:0]      aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
   logic [AXIL_DATA_W-1:0]     w_data_q, w_data_d;
   logic [AXIL_DATA_BYTES-1:0] w_strb_q, w_strb_d;
   logic                       last_wr_q, last_wr_d;
   logic [TMR_W-1:0]           tmr_q, tmr_d;
   logic                       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]                 bresp_q, bresp_d, rresp_q, rresp_d;
   logic [AXIL_DATA_W-1:0]     rdata_q, rdata_d;
   logic                       req_vld_q, req_vld_d, req_wen_q, req_wen_d;
   logic [AXIL_ADD_W-1:0]      req_add_q, req_add_d;
   logic [AXIL_DATA_W-1:0]     req_wdata_q, req_wdata_d;
   logic [AXIL_DATA_BYTES-1:0] req_wstrb_q, req_wstrb_d;
   logic                       wr_pend, rd_pend, pick_wr;

   function automatic logic addr_oor(input logic [AXIL_ADD_W-1:0] addr);
      return 64'(addr) >= 64'(ADD_RANGE);
   endfunction

   always_comb begin
      state_d     = state_q;
      aw_held_d   = aw_held_q;
      w_held_d    = w_held_q;
      ar_held_d   = ar_held_q;
      aw_addr_d   = aw_addr_q;
      ar_addr_d   = ar_addr_q;
      w_data_d    = w_data_q;
      w_strb_d    = w_strb_q;
      last_wr_d   = last_wr_q;
      tmr_d       = tmr_q;
      bvalid_d    = bvalid_q;
      rvalid_d    = rvalid_q;
      bresp_d     = bresp_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
      req_vld_d   = req_vld_q;
      req_wen_d   = req_wen_q;
      req_add_d   = req_add_q;
      req_wdata_d = req_wdata_q;
      req_wstrb_d = req_wstrb_q;
      wr_pend     = aw_held_q && w_held_q;
      rd_pend     = ar_held_q;
      // last_wr remembers who won the previous tie, so ties alternate.
      pick_wr     = wr_pend && (!rd_pend || !last_wr_q);

      // Capture only when ready, i.e. the slot is empty, so capture and
      // consumption of the same slot never coincide.
      if (s_axil_awvalid && awready_q) begin
         aw_held_d = 1'b1;
         aw_addr_d = s_axil_awaddr;
      end
      if (s_axil_wvalid && wready_q) begin
         w_held_d = 1'b1;
         w_data_d = s_axil_wdata;
         w_strb_d = s_axil_wstrb;
      end
      if (s_axil_arvalid && arready_q) begin
         ar_held_d = 1'b1;
         ar_addr_d = s_axil_araddr;
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_pend && rd_pend) last_wr_d = pick_wr;
            if (pick_wr) begin
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               if (addr_oor(aw_addr_q)) begin
                  bvalid_d = 1'b1;
                  bresp_d  = RESP_DECERR;
                  state_d  = ST_WRESP;
               end else begin
                  req_vld_d   = 1'b1;
                  req_wen_d   = 1'b1;
                  req_add_d   = {aw_addr_q[AXIL_ADD_W-1:2], 2'b00};
                  req_wdata_d = w_data_q;
                  req_wstrb_d = w_strb_q;
                  tmr_d       = TMR_LOAD;
                  state_d     = ST_REQ;
               end
            end else if (rd_pend) begin
               ar_held_d = 1'b0;
               if (addr_oor(ar_addr_q)) begin
                  rvalid_d = 1'b1;
                  rresp_d  = RESP_DECERR;
                  rdata_d  = '0;
                  state_d  = ST_RRESP;
               end else begin
                  req_vld_d = 1'b1;
                  req_wen_d = 1'b0;
                  req_add_d = {ar_addr_q[AXIL_ADD_W-1:2], 2'b00};
                  tmr_d     = TMR_LOAD;
                  state_d   = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            // Ack is tested first so it wins over a coincident timeout.
            if (reg_ack || tmr_q == '0) begin
               req_vld_d = 1'b0;
               if (req_wen_q) begin
                  bvalid_d = 1'b1;
                  bresp_d  = reg_ack ? RESP_OKAY : RESP_SLVERR;
                  state_d  = ST_WRESP;
               end else begin
                  rvalid_d = 1'b1;
                  rresp_d  = reg_ack ? RESP_OKAY : RESP_SLVERR;
                  rdata_d  = reg_ack ? reg_rdata : '0;
                  state_d  = ST_RRESP;
               end
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_WRESP: begin
            if (s_axil_bready) begin
               bvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         ST_RRESP: begin
            if (s_axil_rready) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      awready_d = !aw_held_d;
      wready_d  = !w_held_d;
      arready_d = !ar_held_d;
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_q     <= ST_IDLE;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         ar_held_q   <= 1'b0;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         arready_q   <= 1'b0;
         aw_addr_q   <= '0;
         ar_addr_q   <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         last_wr_q   <= 1'b0;
         tmr_q       <= '0;
         bvalid_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         bresp_q     <= '0;
         rresp_q     <= '0;
         rdata_q     <= '0;
         req_vld_q   <= 1'b0;
         req_wen_q   <= 1'b0;
         req_add_q   <= '0;
         req_wdata_q <= '0;
         req_wstrb_q <= '0;
      end else begin
         state_q     <= state_d;
         aw_held_q   <= aw_held_d;
         w_held_q    <= w_held_d;
         ar_held_q   <= ar_held_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         arready_q   <= arready_d;
         aw_addr_q   <= aw_addr_d;
         ar_addr_q   <= ar_addr_d;
         w_data_q    <= w_data_d;
         w_strb_q    <= w_strb_d;
         last_wr_q   <= last_wr_d;
         tmr_q       <= tmr_d;
         bvalid_q    <= bvalid_d;
         rvalid_q    <= rvalid_d;
         bresp_q     <= bresp_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         req_vld_q   <= req_vld_d;
         req_wen_q   <= req_wen_d;
         req_add_q   <= req_add_d;
         req_wdata_q <= req_wdata_d;
         req_wstrb_q <= req_wstrb_d;
      end
   end

   assign s_axil_awready = awready_q;
   assign s_axil_wready  = wready_q;
   assign s_axil_arready = arready_q;
   assign s_axil_bvalid  = bvalid_q;
   assign s_axil_bresp   = bresp_q;
   assign s_axil_rvalid  = rvalid_q;
   assign s_axil_rresp   = rresp_q;
   assign s_axil_rdata   = rdata_q;
   assign reg_req_vld    = req_vld_q;
   assign reg_req_wen    = req_wen_q;
   assign reg_req_add    = req_add_q;
   assign reg_req_wdata  = req_wdata_q;
   assign reg_req_wstrb  = req_wstrb_q;

endmodule

// File: tb/tb_axi_if_axil2reg.sv
// tb_axi_if_axil2reg
//   Self-checking bench for axi_if_axil2reg with ADD_RANGE=0x20000 and
//   TIMEOUT=16. A register-file responder answers requests after a
//   programmable delay; a word-level memory model predicts responses.

module tb_axi_if_axil2reg;
   localparam int          TMO   = 16;
   localparam int unsigned RANGE = 32'h20000;

   logic        clk = 1'b0;
   logic        s_rst = 1'b1;
   logic [17:0] awaddr = '0, araddr = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        awready, wready, arready, bvalid, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic        reg_req_vld, reg_req_wen;
   logic [17:0] reg_req_add;
   logic [31:0] reg_req_wdata;
   logic [3:0]  reg_req_wstrb;
   logic        reg_ack = 1'b0;
   logic [31:0] reg_rdata = '0;

   int     errors = 0, checks = 0;
   longint cyc = 0;
   int     b_count = 0, r_count = 0;

   always #5 clk = ~clk;

   axi_if_axil2reg #(.ADD_RANGE(RANGE), .TIMEOUT(TMO)) dut (
      .clk(clk), .s_rst(s_rst),
      .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
      .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
      .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
      .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
      .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
      .reg_req_vld(reg_req_vld), .reg_req_wen(reg_req_wen), .reg_req_add(reg_req_add),
      .reg_req_wdata(reg_req_wdata), .reg_req_wstrb(reg_req_wstrb),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata)
   );

   always @(posedge clk) begin
      cyc++;
      if (bvalid && bready) b_count++;
      if (rvalid && rready) r_count++;
   end

   // ---------------- memory helpers ----------------
   function automatic logic [31:0] dflt(input int w);
      return 32'h5EED_0000 ^ 32'(w);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // register file seen by the DUT
   logic [31:0] rf_mem [int];
   // reference model, updated from the stimulus
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] ref_rd(input logic [17:0] a);
      int w = int'(a >> 2);
      return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
   endfunction

   function automatic void ref_wr(input logic [17:0] a, input logic [31:0] d, input logic [3:0] s);
      ref_mem[int'(a >> 2)] = merge(ref_rd(a), d, s);
   endfunction

   // ---------------- register-file responder ----------------
   typedef struct packed {
      logic        wen;
      logic [17:0] add;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   req_t req_log[$];
   req_t cur;
   int   ack_delay = 0;     // -1: never acknowledge
   logic stray_ack = 1'b0;
   int   req_cycles = 0, last_req_len = 0;
   logic unstable = 1'b0;

   always @(negedge clk) begin
      int w;
      reg_ack = 1'b0;
      if (stray_ack) begin
         reg_ack   = 1'b1;
         stray_ack = 1'b0;
      end
      if (reg_req_vld) begin
         if (req_cycles == 0) begin
            cur = '{reg_req_wen, reg_req_add, reg_req_wdata, reg_req_wstrb};
            req_log.push_back(cur);
         end else if (cur !== req_t'({reg_req_wen, reg_req_add, reg_req_wdata, reg_req_wstrb})) begin
            unstable = 1'b1;
         end
         if (ack_delay >= 0 && req_cycles == ack_delay) begin
            reg_ack = 1'b1;
            w = int'(reg_req_add >> 2);
            if (reg_req_wen)
               rf_mem[w] = merge(rf_mem.exists(w) ? rf_mem[w] : dflt(w), reg_req_wdata, reg_req_wstrb);
            else
               reg_rdata = rf_mem.exists(w) ? rf_mem[w] : dflt(w);
         end
         req_cycles++;
      end else begin
         if (req_cycles != 0) last_req_len = req_cycles;
         req_cycles = 0;
      end
   end

   // ---------------- AXI master tasks ----------------
   task automatic send_aw(input logic [17:0] a);
      int n = 0;
      @(negedge clk);
      awaddr = a; awvalid = 1'b1;
      while (!awready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL aw_handshake timed out"); end
      @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(negedge clk);
      wdata = d; wstrb = s; wvalid = 1'b1;
      while (!wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL w_handshake timed out"); end
      @(negedge clk);
      wvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [17:0] a);
      int n = 0;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      while (!arready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin checks++; errors++; $display("FAIL ar_handshake timed out"); end
      @(negedge clk);
      arvalid = 1'b0;
   endtask

   task automatic wait_b(output logic [1:0] resp, output bit ok);
      int n = 0;
      while (!bvalid && n < 200) begin @(negedge clk); n++; end
      ok = bvalid; resp = bresp;
      if (ok) begin bready = 1'b1; @(negedge clk); bready = 1'b0; end
   endtask

   task automatic wait_r(output logic [31:0] d, output logic [1:0] resp, output bit ok);
      int n = 0;
      while (!rvalid && n < 200) begin @(negedge clk); n++; end
      ok = rvalid; resp = rresp; d = rdata;
      if (ok) begin rready = 1'b1; @(negedge clk); rready = 1'b0; end
   endtask

   task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output bit ok);
      fork
         send_aw(a);
         send_w(d, s);
      join
      wait_b(resp, ok);
   endtask

   task automatic do_read(input logic [17:0] a, output logic [31:0] d, output logic [1:0] resp, output bit ok);
      send_ar(a);
      wait_r(d, resp, ok);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      s_rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, reg_req_vld, reg_req_wen} !== 7'b0 ||
          bresp !== 2'b0 || rresp !== 2'b0 || rdata !== 32'b0 || reg_req_add !== 18'b0 ||
          reg_req_wdata !== 32'b0 || reg_req_wstrb !== 4'b0) begin
         errors++;
         $display("FAIL reset_values: rdy=%b%b%b bv=%b rv=%b vld=%b", awready, wready, arready, bvalid, rvalid, reg_req_vld);
      end
      s_rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++; $display("FAIL ready_after_reset: got %b%b%b want 111", awready, wready, arready);
      end
   endtask

   task automatic test_single_write();
      logic [1:0] resp; bit ok;
      ack_delay = 3; req_log.delete(); unstable = 1'b0;
      do_write(18'h00104, 32'hA5A5_5A5A, 4'hF, resp, ok);
      ref_wr(18'h00104, 32'hA5A5_5A5A, 4'hF);
      checks++;
      if (!ok || resp !== 2'b00) begin errors++; $display("FAIL single_write_bresp: ok=%0d got %b want 00", ok, resp); end
      checks++;
      if (req_log.size() != 1) begin
         errors++; $display("FAIL single_write_reqs: got %0d want 1", req_log.size());
      end else begin
         checks++;
         if (req_log[0] !== req_t'({1'b1, 18'h00104, 32'hA5A5_5A5A, 4'hF})) begin
            errors++; $display("FAIL single_write_fields: got %h want %h", req_log[0], req_t'({1'b1, 18'h00104, 32'hA5A5_5A5A, 4'hF}));
         end
      end
      checks++;
      if (last_req_len != 4 || unstable) begin
         errors++; $display("FAIL single_write_req_len: got %0d want 4 unstable=%0d", last_req_len, unstable);
      end
   endtask

   task automatic test_latency();
      longint c0, c_vld, c_b;
      int n = 0;
      ack_delay = 0; c_vld = -1;
      @(negedge clk);
      awaddr = 18'h00080; awvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1'b1;
      c0 = cyc;
      checks++;
      if (!(awready && wready)) begin errors++; $display("FAIL latency_ready: got %b%b want 11", awready, wready); end
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      while (!bvalid && n < 20) begin
         if (reg_req_vld && c_vld < 0) c_vld = cyc;
         @(negedge clk); n++;
      end
      c_b = cyc;
      ref_wr(18'h00080, 32'hCAFE_0001, 4'hF);
      checks++;
      if (c_vld != c0 + 2) begin errors++; $display("FAIL latency_req_vld: got +%0d want +2", c_vld - c0); end
      checks++;
      if (!bvalid || c_b != c0 + 3 || bresp !== 2'b00) begin
         errors++; $display("FAIL latency_bvalid: got +%0d bv=%b resp=%b want +3 1 00", c_b - c0, bvalid, bresp);
      end
      bready = 1'b1; @(negedge clk); bready = 1'b0;
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; bit ok; int b0;
      ack_delay = 1; req_log.delete();
      send_w(32'h0F0F_1234, 4'b0101);
      repeat (2) @(negedge clk);
      checks++;
      if (req_log.size() != 0 || reg_req_vld !== 1'b0) begin
         errors++; $display("FAIL w_only_no_req: got %0d reqs vld=%b want 0", req_log.size(), reg_req_vld);
      end
      b0 = b_count;
      send_aw(18'h00202);
      wait_b(resp, ok);
      ref_wr(18'h00202, 32'h0F0F_1234, 4'b0101);
      checks++;
      if (!ok || resp !== 2'b00) begin errors++; $display("FAIL w_first_bresp: ok=%0d got %b want 00", ok, resp); end
      checks++;
      if (req_log.size() != 1 || req_log[0] !== req_t'({1'b1, 18'h00200, 32'h0F0F_1234, 4'b0101})) begin
         errors++; $display("FAIL w_first_req: n=%0d got %h", req_log.size(), req_log.size() ? req_log[0] : req_t'(0));
      end
      repeat (5) @(negedge clk);
      checks++;
      if (b_count != b0 + 1 || bvalid) begin errors++; $display("FAIL w_first_one_b: got %0d want 1", b_count - b0); end
   endtask

   task automatic test_read_stall();
      logic [1:0] resp; bit ok; int n = 0;
      ack_delay = 0;
      do_write(18'h00010, 32'h1234_5678, 4'hF, resp, ok);
      ref_wr(18'h00010, 32'h1234_5678, 4'hF);
      ack_delay = 2;
      send_ar(18'h00010);
      while (!rvalid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!rvalid || rdata !== ref_rd(18'h00010) || rresp !== 2'b00) begin
         errors++; $display("FAIL read_data: rv=%b got %h/%b want %h/00", rvalid, rdata, rresp, ref_rd(18'h00010));
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00) begin
            errors++; $display("FAIL read_hold_%0d: rv=%b got %h want 12345678", i, rvalid, rdata);
         end
      end
      rready = 1'b1; @(negedge clk); rready = 1'b0;
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin errors++; $display("FAIL read_release: rvalid got %b want 0", rvalid); end
   endtask

   task automatic test_arbitration();
      logic [1:0] br, rr; logic [31:0] rd; bit okb, okr;
      logic tie_wr = 1'b1;   // the first tie after reset goes to the write
      logic [17:0] wa, ra;
      ack_delay = 0;
      for (int round = 0; round < 2; round++) begin
         wa = 18'h00400 + 18'(round * 8);
         ra = 18'h00500 + 18'(round * 8);
         req_log.delete();
         fork
            send_aw(wa);
            send_w(32'h1111_0000 + 32'(round), 4'hF);
            send_ar(ra);
         join
         fork
            wait_b(br, okb);
            wait_r(rd, rr, okr);
         join
         checks++;
         if (req_log.size() != 2 || req_log[0].wen !== tie_wr || req_log[1].wen !== !tie_wr) begin
            errors++; $display("FAIL arb_order_%0d: n=%0d first_wen=%b want %b", round, req_log.size(),
                               req_log.size() ? req_log[0].wen : 1'bx, tie_wr);
         end
         checks++;
         if (!okb || !okr || br !== 2'b00 || rr !== 2'b00 || rd !== ref_rd(ra)) begin
            errors++; $display("FAIL arb_resp_%0d: b=%b r=%b rd=%h want 00 00 %h", round, br, rr, rd, ref_rd(ra));
         end
         ref_wr(wa, 32'h1111_0000 + 32'(round), 4'hF);
         tie_wr = !tie_wr;
      end
   endtask

   task automatic test_decerr();
      logic [1:0] resp; logic [31:0] d; bit ok;
      ack_delay = 0; req_log.delete();
      do_read(18'h3FFFC, d, resp, ok);
      checks++;
      if (!ok || resp !== 2'b11 || d !== 32'h0 || req_log.size() != 0) begin
         errors++; $display("FAIL decerr_read: got %b/%h reqs=%0d want 11/0/0", resp, d, req_log.size());
      end
      do_write(18'h20000, 32'hDEAD_BEEF, 4'hF, resp, ok);
      checks++;
      if (!ok || resp !== 2'b11 || req_log.size() != 0) begin
         errors++; $display("FAIL decerr_write: got %b reqs=%0d want 11/0", resp, req_log.size());
      end
      do_read(18'h1FFFC, d, resp, ok);
      checks++;
      if (!ok || resp !== 2'b00 || d !== ref_rd(18'h1FFFC) || req_log.size() != 1) begin
         errors++; $display("FAIL edge_in_range: got %b/%h want 00/%h", resp, d, ref_rd(18'h1FFFC));
      end
   endtask

   task automatic test_timeout();
      logic [1:0] resp; logic [31:0] d; bit ok; int n = 0;
      ack_delay = -1; req_log.delete();
      send_ar(18'h00040);
      while (!rvalid && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      checks++;
      if (!rvalid || rresp !== 2'b10 || rdata !== 32'h0) begin
         errors++; $display("FAIL timeout_resp: rv=%b got %b/%h want 10/0", rvalid, rresp, rdata);
      end
      checks++;
      if (last_req_len != TMO) begin errors++; $display("FAIL timeout_len: got %0d want %0d", last_req_len, TMO); end
      stray_ack = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (!rvalid || rresp !== 2'b10 || rdata !== 32'h0 || reg_req_vld) begin
         errors++; $display("FAIL late_ack_ignored: rv=%b got %b/%h", rvalid, rresp, rdata);
      end
      rready = 1'b1; @(negedge clk); rready = 1'b0;
      // Ack on the very last REQ cycle must win over the timeout.
      ack_delay = TMO - 1;
      do_read(18'h00010, d, resp, ok);
      checks++;
      if (!ok || resp !== 2'b00 || d !== ref_rd(18'h00010)) begin
         errors++; $display("FAIL ack_wins: got %b/%h want 00/%h", resp, d, ref_rd(18'h00010));
      end
      ack_delay = -1;
      do_write(18'h00044, 32'h7777_7777, 4'hF, resp, ok);
      checks++;
      if (!ok || resp !== 2'b10) begin errors++; $display("FAIL write_timeout: got %b want 10", resp); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [31:0] d; bit ok; int n = 0, b0, r0;
      ack_delay = -1;
      fork
         send_aw(18'h00300);
         send_w(32'hBAD0_BAD0, 4'hF);
      join
      while (!reg_req_vld && n < 50) begin @(negedge clk); n++; end
      s_rst = 1'b1;
      @(negedge clk);
      checks++;
      if (reg_req_vld !== 1'b0 || bvalid !== 1'b0) begin
         errors++; $display("FAIL reset_mid_req: vld=%b bv=%b want 0 0", reg_req_vld, bvalid);
      end
      s_rst = 1'b0;
      b0 = b_count; r0 = r_count;
      repeat (20) @(negedge clk);
      checks++;
      if (b_count != b0 || r_count != r0 || bvalid || rvalid) begin
         errors++; $display("FAIL reset_mid_no_resp: got b=%0d r=%0d want 0", b_count - b0, r_count - r0);
      end
      ack_delay = 0;
      do_write(18'h00300, 32'h600D_600D, 4'b0011, resp, ok);
      ref_wr(18'h00300, 32'h600D_600D, 4'b0011);
      do_read(18'h00300, d, resp, ok);
      checks++;
      if (!ok || resp !== 2'b00 || d !== ref_rd(18'h00300)) begin
         errors++; $display("FAIL reset_mid_after: got %b/%h want 00/%h", resp, d, ref_rd(18'h00300));
      end
   endtask

   task automatic test_random();
      logic [1:0] resp, eresp; logic [31:0] d, dd; logic [3:0] s; logic [17:0] a; bit ok, wr, oor;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) a = 18'($urandom_range(0, 32'h3FFFF));
         else a = 18'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
         dd = $urandom;
         s = 4'($urandom_range(0, 15));
         ack_delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
         oor = (32'(a) >= RANGE);
         eresp = oor ? 2'b11 : (ack_delay < 0) ? 2'b10 : 2'b00;
         req_log.delete();
         if (wr) begin
            do_write(a, dd, s, resp, ok);
            if (eresp == 2'b00) ref_wr(a, dd, s);
            checks++;
            if (!ok || resp !== eresp) begin errors++; $display("FAIL rand_wr_%0d a=%h: got %b want %b", i, a, resp, eresp); end
         end else begin
            do_read(a, d, resp, ok);
            checks++;
            if (!ok || resp !== eresp || d !== ((eresp == 2'b00) ? ref_rd(a) : 32'h0)) begin
               errors++; $display("FAIL rand_rd_%0d a=%h: got %b/%h want %b/%h", i, a, resp, d, eresp,
                                  (eresp == 2'b00) ? ref_rd(a) : 32'h0);
            end
         end
         checks++;
         if (req_log.size() != (oor ? 0 : 1) ||
             (!oor && (req_log[0].wen !== wr || req_log[0].add !== {a[17:2], 2'b00} ||
                       (wr && (req_log[0].wdata !== dd || req_log[0].wstrb !== s))))) begin
            errors++; $display("FAIL rand_req_%0d a=%h: n=%0d", i, a, req_log.size());
         end
      end
      ack_delay = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_latency();
      test_w_before_aw();
      test_read_stall();
      test_arbitration();
      test_decerr();
      test_timeout();
      test_reset_mid();
      test_random();
      checks++;
      if (unstable) begin errors++; $display("FAIL req_stable: request fields changed while vld held"); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
